// File: rtl/basket_checkout_sequencer_if.sv
// basket_checkout_sequencer_if: request/status, price ROM and VGA sharing signals of the checkout sequencer.
interface basket_checkout_sequencer_if;
    logic        ADD_REQ;
    logic        CANCEL_REQ;
    logic        CLEAR_REQ;
    logic [3:0]  REQ_ID;
    logic [3:0]  REQ_QTT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] T_PRICE;
    logic [3:0]  ITEM_COUNT;
    logic        ROM_RD;
    logic [3:0]  ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic        VGA_ROM_REQ;
    logic [3:0]  VGA_ROM_ADDR;
    logic        VGA_ROM_GNT;
    logic        VGA_ROM_VALID;

    modport slave (
        input  ADD_REQ, CANCEL_REQ, CLEAR_REQ, REQ_ID, REQ_QTT, ROM_DATA, VGA_ROM_REQ, VGA_ROM_ADDR,
        output BUSY, DONE, ERR, T_PRICE, ITEM_COUNT, ROM_RD, ROM_ADDR, VGA_ROM_GNT, VGA_ROM_VALID
    );

    modport master (
        output ADD_REQ, CANCEL_REQ, CLEAR_REQ, REQ_ID, REQ_QTT, ROM_DATA, VGA_ROM_REQ, VGA_ROM_ADDR,
        input  BUSY, DONE, ERR, T_PRICE, ITEM_COUNT, ROM_RD, ROM_ADDR, VGA_ROM_GNT, VGA_ROM_VALID
    );
endinterface

// File: rtl/basket_checkout_sequencer.sv
// basket_checkout_sequencer: add/cancel/clear sequencer with shared price ROM and subtotal LIFO.
// Optional BULK_DISCOUNT_EN adds a DISC state taking 1/8 off adds with quantity >= BULK_QTT.
module basket_checkout_sequencer #(
    parameter int MAX_ITEMS    = 12,
    parameter int NUM_PRODUCTS = 12,
    parameter int STARVE_LIMIT = 8
`ifdef BULK_DISCOUNT_EN
    , parameter int BULK_QTT   = 5
`endif
) (
    input logic                        CLOCK_50,
    input logic                        RESET_N,
    basket_checkout_sequencer_if.slave bus
);
    localparam int              WW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [4:0]      NPROD = 5'(NUM_PRODUCTS);
    localparam logic [3:0]      MAXC  = 4'(MAX_ITEMS);
    localparam logic [WW-1:0]   SLIM  = WW'(STARVE_LIMIT);
`ifdef BULK_DISCOUNT_EN
    localparam logic [3:0]      BQ    = 4'(BULK_QTT);
`endif

    typedef enum logic [2:0] {
        IDLE, ARB, LAT, MUL, ACC, POP, FIN
`ifdef BULK_DISCOUNT_EN
        , DISC
`endif
    } state_t;

    state_t        state_q;
    logic [WW-1:0] wait_q;
    logic [3:0]    id_q;
    logic [3:0]    qtt_q;
    logic [3:0]    cnt_q;
    logic [1:0]    it_q;
    logic [19:0]   mcand_q;
    logic [19:0]   prod_q;
    logic [15:0]   total_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          vvalid_q;
    logic [15:0]   lifo_q [MAX_ITEMS];
    logic          seq_gnt;
    logic          push;
    logic [20:0]   sum;

    // The sequencer owns the ROM only in ARB when VGA is idle or has starved it long enough
    assign seq_gnt           = state_q == ARB && (!bus.VGA_ROM_REQ || wait_q == SLIM);
    assign bus.ROM_RD        = seq_gnt | bus.VGA_ROM_REQ;
    assign bus.ROM_ADDR      = seq_gnt ? id_q : bus.VGA_ROM_ADDR;
    assign bus.VGA_ROM_GNT   = bus.VGA_ROM_REQ & !seq_gnt;
    assign bus.VGA_ROM_VALID = vvalid_q;
    assign bus.BUSY          = busy_q;
    assign bus.DONE          = done_q;
    assign bus.ERR           = err_q;
    assign bus.T_PRICE       = total_q;
    assign bus.ITEM_COUNT    = cnt_q;

    assign sum  = {5'd0, total_q} + {1'b0, prod_q};
    assign push = state_q == ACC && sum[20:16] == 5'd0;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            id_q     <= '0;
            qtt_q    <= '0;
            cnt_q    <= '0;
            it_q     <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            total_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vvalid_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vvalid_q <= bus.VGA_ROM_GNT;
            case (state_q)
                IDLE: begin
                    if (bus.CLEAR_REQ) begin
                        total_q <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else if (bus.CANCEL_REQ) begin
                        busy_q  <= 1'b1;
                        state_q <= POP;
                    end else if (bus.ADD_REQ) begin
                        id_q  <= bus.REQ_ID;
                        qtt_q <= bus.REQ_QTT;
                        if (bus.REQ_QTT == 4'd0 || {1'b0, bus.REQ_ID} >= NPROD || cnt_q == MAXC) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (seq_gnt) begin
                        wait_q  <= '0;
                        state_q <= LAT;
                    end else begin
                        wait_q  <= wait_q + WW'(1);
                    end
                end
                LAT: begin
                    mcand_q <= {4'd0, bus.ROM_DATA};
                    prod_q  <= '0;
                    it_q    <= '0;
                    state_q <= MUL;
                end
                MUL: begin
                    prod_q  <= prod_q + (qtt_q[it_q] ? mcand_q : 20'd0);
                    mcand_q <= mcand_q << 1;
                    it_q    <= it_q + 2'd1;
                    if (it_q == 2'd3) begin
`ifdef BULK_DISCOUNT_EN
                        state_q <= qtt_q >= BQ ? DISC : ACC;
`else
                        state_q <= ACC;
`endif
                    end
                end
`ifdef BULK_DISCOUNT_EN
                DISC: begin
                    prod_q  <= prod_q - (prod_q >> 3);
                    state_q <= ACC;
                end
`endif
                ACC: begin
                    if (push) begin
                        total_q <= sum[15:0];
                        cnt_q   <= cnt_q + 4'd1;
                    end else begin
                        err_q   <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                POP: begin
                    if (cnt_q == 4'd0) begin
                        err_q   <= 1'b1;
                    end else begin
                        total_q <= total_q - lifo_q[cnt_q - 4'd1];
                        cnt_q   <= cnt_q - 4'd1;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // ITEM_COUNT doubles as the LIFO pointer, so the store needs no reset
    always_ff @(posedge CLOCK_50) begin
        if (push) lifo_q[cnt_q] <= prod_q[15:0];
    end
endmodule

// File: doc/basket_checkout_sequencer.md
Name: basket_checkout_sequencer

Overview:
- Sequences product add, cancel and clear commands into a running basket total for the sale terminal.
- Looks up unit prices in the shared product price ROM and multiplies by quantity with a multi-cycle shift-add.
- Keeps a LIFO of per-item subtotals so cancel removes the last item exactly.
- Arbitrates the single-port price ROM between itself and the VGA renderer, which reads prices for the product list.

Parameters:
- MAX_ITEMS, 12, basket capacity and subtotal LIFO depth.
- NUM_PRODUCTS, 12, valid product IDs are 0..NUM_PRODUCTS-1.
- STARVE_LIMIT, 8, consecutive cycles the sequencer may wait on the ROM before it preempts VGA.
- BULK_QTT, 5, quantity threshold for the optional discount.

Ports:
- CLOCK_50  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- ADD_REQ  in  1  one-cycle pulse: add REQ_QTT units of REQ_ID.
- CANCEL_REQ  in  1  one-cycle pulse: remove last added item.
- CLEAR_REQ  in  1  one-cycle pulse: empty basket.
- REQ_ID  in  4  product ID for add.
- REQ_QTT  in  4  quantity for add.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse, coincident with DONE, when the request was rejected.
- T_PRICE  out  16  basket total.
- ITEM_COUNT  out  4  number of entries in the basket.
- ROM_RD  out  1  ROM read strobe.
- ROM_ADDR  out  4  ROM address.
- ROM_DATA  in  16  ROM read data, valid 1 cycle after ROM_RD.
- VGA_ROM_REQ  in  1  VGA requests a ROM read.
- VGA_ROM_ADDR  in  4  VGA read address.
- VGA_ROM_GNT  out  1  VGA request granted this cycle (combinational).
- VGA_ROM_VALID  out  1  ROM_DATA holds VGA data this cycle.

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET_N is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, LIFO empty.
- Request sampling:
  - Requests are sampled only in IDLE. Pulses arriving while BUSY are dropped.
  - Simultaneous requests resolve by priority: CLEAR > CANCEL > ADD.
  - REQ_ID and REQ_QTT are latched on the sampling edge.
- States:
  - IDLE.
  - ARB: wait for ROM.
  - LAT: ROM latency.
  - MUL: 4 iterations.
  - ACC.
  - POP.
  - FIN.
- ADD path:
  - IDLE -> ARB.
  - In ARB, the sequencer gets the ROM when VGA_ROM_REQ=0, or when its wait counter reaches STARVE_LIMIT. It then drives ROM_RD=1, ROM_ADDR=latched ID, and goes to LAT. Otherwise VGA_ROM_GNT=VGA_ROM_REQ and the wait counter increments.
  - LAT: capture ROM_DATA as the unit price.
  - MUL: 4 cycles of LSB-first shift-add over QTT bits, into a 20-bit product.
  - ACC: update totals, then FIN.
- ADD latency: with no contention, DONE is high on the 8th cycle after the sampling edge. Each contention cycle adds one.
- ADD rejection:
  - Add is rejected (ERR=1, DONE=1, no state change) when any of these hold: REQ_QTT=0, REQ_ID>=NUM_PRODUCTS, ITEM_COUNT=MAX_ITEMS, or product+T_PRICE > 16'hFFFF.
  - ID, QTT and full checks are made in IDLE and go straight to FIN without a ROM access. The overflow check is made in ACC.
- ADD success: in ACC, push the 16-bit subtotal onto the LIFO, ITEM_COUNT+1, T_PRICE+=subtotal.
- CANCEL path:
  - IDLE -> POP. POP subtracts the LIFO top from T_PRICE and does ITEM_COUNT-1. Then FIN.
  - DONE on the 2nd cycle after sampling.
  - CANCEL with ITEM_COUNT=0 gives ERR, with no change.
- CLEAR: T_PRICE=0, ITEM_COUNT=0, LIFO pointer=0, then FIN. DONE on the next cycle.
- FIN: DONE=1 (with ERR if rejected) for one cycle, BUSY=0, return to IDLE. BUSY is high from the cycle after sampling through the cycle before DONE.
- VGA arbitration:
  - When the sequencer is not in ARB-with-grant, VGA_ROM_GNT=VGA_ROM_REQ, ROM_RD=VGA_ROM_REQ and ROM_ADDR=VGA_ROM_ADDR.
  - VGA_ROM_VALID is the registered VGA_ROM_GNT.
  - On a preemption cycle, VGA_ROM_GNT=0 and VGA must hold its request.
- Wait counter: reset when the sequencer is granted. It never exceeds STARVE_LIMIT.
- Reset mid-operation: an asserted RESET_N aborts immediately to the reset values, with no DONE.

Optional Feature:
- Macro: BULK_DISCOUNT_EN.
- When defined: if the latched QTT>=BULK_QTT, an extra DISC state between MUL and ACC sets subtotal = product - (product>>3), truncating. This adds 1 cycle of latency for those adds only, and the overflow check uses the discounted value.
- When undefined: no DISC state, and the subtotal equals the product.

Test Plan:
- Reset, then ADD ID=3 QTT=2 with ROM[3]=150 and VGA idle -> DONE on cycle 8, T_PRICE=300, ITEM_COUNT=1, ERR=0.
- Two adds (ROM[1]=100 QTT=1, ROM[2]=250 QTT=3), then CANCEL -> T_PRICE=850, then 100, ITEM_COUNT=1; a second CANCEL gives 0; a third CANCEL gives ERR=1 with T_PRICE=0.
- VGA_ROM_REQ held high, then ADD -> VGA_ROM_GNT low exactly on cycle STARVE_LIMIT(8) of ARB, the sequencer reads, and VGA_ROM_VALID shows no sample for that slot.
- ADD QTT=0; ADD ID=12; 12 valid adds then a 13th; an add making the total exceed 65535 -> ERR on each rejected add, with totals and count unchanged.
- ADD and CLEAR pulsed in the same cycle, with a prior total of 500 -> CLEAR wins: DONE next cycle, T_PRICE=0; RESET_N asserted mid-MUL -> outputs 0 at once, no DONE.
- With BULK_DISCOUNT_EN defined, ADD ROM=80 QTT=5 -> T_PRICE=350 on cycle 9.
